// File: rtl/conv_stream_driver_if.sv
// Bundles the pixel-source handshake and the filter-facing coefficient/pixel
// lanes of conv_stream_driver; master is the driver, slave is its environment.
interface conv_stream_driver_if #(
  parameter int DATA_W  = 8,
  parameter int COEFF_W = 16
);
  logic               pix_valid;
  logic [DATA_W-1:0]  pix_data;
  logic               pix_ready;
  logic               config_load;
  logic [COEFF_W-1:0] coeff_out;
  logic               frame_sync;
  logic [DATA_W-1:0]  data_out;

  modport master (
    input  pix_valid, pix_data,
    output pix_ready, config_load, coeff_out, frame_sync, data_out
  );

  modport slave (
    output pix_valid, pix_data,
    input  pix_ready, config_load, coeff_out, frame_sync, data_out
  );
endinterface

// File: rtl/conv_stream_driver.sv
// Replays a 5x5 coefficient mask into the convolution filter, then streams
// whole pixel frames from an upstream valid/ready source with no gaps.
module conv_stream_driver #(
  parameter int IMG_W     = 128,
  parameter int IMG_H     = 128,
  parameter int DATA_W    = 8,
  parameter int COEFF_W   = 16,
  parameter int NUM_COEFF = 25
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               io_coeff_wr_en,
  input  logic [4:0]         io_coeff_wr_addr,
  input  logic [COEFF_W-1:0] io_coeff_wr_data,
  input  logic               io_start,
  input  logic               io_stop,
  input  logic [15:0]        io_num_frames,
  output logic               io_busy,
  output logic               io_frame_done,
  output logic               io_underrun,
  conv_stream_driver_if.master bus
);

  localparam int NUM_PIX = IMG_W * IMG_H;
  localparam int PIX_W   = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
  localparam logic [PIX_W-1:0] LAST_PIX   = PIX_W'(NUM_PIX - 1);
  localparam logic [4:0]       LAST_COEFF = 5'(NUM_COEFF - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    STREAM
  } state_t;

  state_t               state_q, state_d;
  logic [4:0]           coeff_idx_q, coeff_idx_d, coeff_idx_inc;
  logic [PIX_W-1:0]     pix_off_q, pix_off_d;
  logic [15:0]          frames_left_q, frames_left_d;
  logic                 continuous_q, continuous_d;
  logic                 stop_seen_q, stop_seen_d;
  logic                 config_load_q, config_load_d;
  logic [COEFF_W-1:0]   coeff_out_q, coeff_out_d;
  logic                 frame_sync_q, frame_sync_d;
  logic [DATA_W-1:0]    data_out_q, data_out_d;
  logic                 busy_q, busy_d;
  logic                 frame_done_q, frame_done_d;
  logic                 underrun_q, underrun_d;
  logic                 pix_ready_c;
  logic                 last_beat;
  logic                 run_ending;
  logic                 coeff_wr_ok;
  logic [COEFF_W-1:0]   coeff_mem [NUM_COEFF];

  // The mask can only change while idle so a replay is never torn.
  assign coeff_wr_ok = io_coeff_wr_en && (state_q == IDLE) &&
                       (io_coeff_wr_addr <= LAST_COEFF);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_COEFF; i++) begin
        coeff_mem[i] <= '0;
      end
    end else if (coeff_wr_ok) begin
      coeff_mem[io_coeff_wr_addr] <= io_coeff_wr_data;
    end
  end

  assign coeff_idx_inc = coeff_idx_q + 5'd1;
  assign last_beat     = (pix_off_q == LAST_PIX);
  assign run_ending    = stop_seen_q || (!continuous_q && (frames_left_q == 16'd1));

  // Every *_d value describes what the filter sees in the next cycle, so the
  // registered outputs line up with ready, which looks one beat ahead.
  always_comb begin
    state_d       = state_q;
    coeff_idx_d   = coeff_idx_q;
    pix_off_d     = pix_off_q;
    frames_left_d = frames_left_q;
    continuous_d  = continuous_q;
    stop_seen_d   = stop_seen_q;
    config_load_d = 1'b0;
    coeff_out_d   = '0;
    frame_sync_d  = 1'b0;
    data_out_d    = '0;
    frame_done_d  = 1'b0;
    underrun_d    = underrun_q;
    pix_ready_c   = 1'b0;

    case (state_q)
      IDLE: begin
        if (io_start) begin
          state_d       = LOAD;
          coeff_idx_d   = 5'd0;
          config_load_d = 1'b1;
          coeff_out_d   = coeff_mem[0];
          underrun_d    = 1'b0;
          frames_left_d = io_num_frames;
          continuous_d  = (io_num_frames == 16'd0);
          stop_seen_d   = 1'b0;
        end
      end

      LOAD: begin
        if (coeff_idx_q == LAST_COEFF) begin
          pix_ready_c  = 1'b1;
          state_d      = STREAM;
          pix_off_d    = '0;
          frame_sync_d = 1'b1;
        end else begin
          coeff_idx_d   = coeff_idx_inc;
          config_load_d = 1'b1;
          coeff_out_d   = coeff_mem[coeff_idx_inc];
        end
      end

      STREAM: begin
        if (io_stop) begin
          stop_seen_d = 1'b1;
        end
        if (!last_beat) begin
          pix_ready_c = 1'b1;
          pix_off_d   = pix_off_q + PIX_W'(1);
        end else if (run_ending) begin
          state_d   = IDLE;
          pix_off_d = '0;
        end else begin
          // A stop raised on the final beat carries into the next frame.
          pix_ready_c  = 1'b1;
          pix_off_d    = '0;
          frame_sync_d = 1'b1;
          stop_seen_d  = io_stop;
          if (!continuous_q) begin
            frames_left_d = frames_left_q - 16'd1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // A missing pixel still consumes its slot so frame geometry is preserved.
    if (pix_ready_c) begin
      if (bus.pix_valid) begin
        data_out_d = bus.pix_data;
      end else begin
        underrun_d = 1'b1;
      end
    end

    frame_done_d = (state_d == STREAM) && (pix_off_d == LAST_PIX);
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      coeff_idx_q   <= '0;
      pix_off_q     <= '0;
      frames_left_q <= '0;
      continuous_q  <= 1'b0;
      stop_seen_q   <= 1'b0;
      config_load_q <= 1'b0;
      coeff_out_q   <= '0;
      frame_sync_q  <= 1'b0;
      data_out_q    <= '0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      underrun_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      coeff_idx_q   <= coeff_idx_d;
      pix_off_q     <= pix_off_d;
      frames_left_q <= frames_left_d;
      continuous_q  <= continuous_d;
      stop_seen_q   <= stop_seen_d;
      config_load_q <= config_load_d;
      coeff_out_q   <= coeff_out_d;
      frame_sync_q  <= frame_sync_d;
      data_out_q    <= data_out_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      underrun_q    <= underrun_d;
    end
  end

  assign bus.pix_ready   = pix_ready_c;
  assign bus.config_load = config_load_q;
  assign bus.coeff_out   = coeff_out_q;
  assign bus.frame_sync  = frame_sync_q;
  assign bus.data_out    = data_out_q;
  assign io_busy         = busy_q;
  assign io_frame_done   = frame_done_q;
  assign io_underrun     = underrun_q;

endmodule

// File: tb/tb_conv_stream_driver.sv
// Directed bench for conv_stream_driver on a reduced 8x4 frame with a ramp
// pixel source; expected coefficients and pixels are written out by hand.
module tb_conv_stream_driver;

  localparam int IMG_W   = 8;
  localparam int IMG_H   = 4;
  localparam int NUM_PIX = IMG_W * IMG_H;

  logic        clk;
  logic        reset_n;
  logic        io_coeff_wr_en;
  logic [4:0]  io_coeff_wr_addr;
  logic [15:0] io_coeff_wr_data;
  logic        io_start;
  logic        io_stop;
  logic [15:0] io_num_frames;
  logic        io_busy;
  logic        io_frame_done;
  logic        io_underrun;

  int          checks;
  int          failures;
  int          src_cnt;
  int          exp_pix;
  bit          exp_under;
  logic [15:0] exp_coeff [25];

  conv_stream_driver_if #(.DATA_W(8), .COEFF_W(16)) bus ();

  conv_stream_driver #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .DATA_W(8), .COEFF_W(16), .NUM_COEFF(25)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .io_coeff_wr_en   (io_coeff_wr_en),
    .io_coeff_wr_addr (io_coeff_wr_addr),
    .io_coeff_wr_data (io_coeff_wr_data),
    .io_start         (io_start),
    .io_stop          (io_stop),
    .io_num_frames    (io_num_frames),
    .io_busy          (io_busy),
    .io_frame_done    (io_frame_done),
    .io_underrun      (io_underrun),
    .bus              (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advances one clock; the ramp source moves on only when a pixel is taken.
  task automatic tick();
    bit acc;
    acc = bus.pix_valid && bus.pix_ready;
    @(posedge clk);
    #1;
    if (acc) src_cnt++;
    bus.pix_data = src_cnt[7:0];
  endtask

  task automatic writeCoeff(input logic [4:0] addr, input logic [15:0] data);
    io_coeff_wr_en   = 1'b1;
    io_coeff_wr_addr = addr;
    io_coeff_wr_data = data;
    tick();
    io_coeff_wr_en   = 1'b0;
  endtask

  task automatic applyStimulus(input logic [15:0] frames);
    io_num_frames = frames;
    io_start      = 1'b1;
    exp_under     = 1'b0;
    tick();
    io_start      = 1'b0;
  endtask

  task automatic checkIdle(input bit under);
    checkOutput("idle_busy",     32'(io_busy),          32'd0);
    checkOutput("idle_cfg_load", 32'(bus.config_load),  32'd0);
    checkOutput("idle_coeff",    32'(bus.coeff_out),    32'd0);
    checkOutput("idle_sync",     32'(bus.frame_sync),   32'd0);
    checkOutput("idle_data",     32'(bus.data_out),     32'd0);
    checkOutput("idle_done",     32'(io_frame_done),    32'd0);
    checkOutput("idle_ready",    32'(bus.pix_ready),    32'd0);
    checkOutput("idle_underrun", 32'(io_underrun),      32'(under));
  endtask

  // Busy pokes: a mask write and a stop during LOAD, both to be ignored.
  task automatic checkLoad(input bit busy_pokes);
    for (int k = 0; k < 25; k++) begin
      checkOutput("load_cfg",      32'(bus.config_load), 32'd1);
      checkOutput("load_coeff",    32'(bus.coeff_out),   32'(exp_coeff[k]));
      checkOutput("load_sync",     32'(bus.frame_sync),  32'd0);
      checkOutput("load_busy",     32'(io_busy),         32'd1);
      checkOutput("load_ready",    32'(bus.pix_ready),   32'(k == 24));
      checkOutput("load_underrun", 32'(io_underrun),     32'd0);
      io_coeff_wr_en   = busy_pokes && (k == 2);
      io_coeff_wr_addr = 5'd3;
      io_coeff_wr_data = 16'hDEAD;
      io_stop          = busy_pokes && (k == 5);
      tick();
    end
    io_coeff_wr_en = 1'b0;
    io_stop        = 1'b0;
  endtask

  task automatic checkStream(input int n_frames, input bit drop, input int stop_frame,
                             input bit start_mid, input bit wr_mid);
    bit         exp_last;
    logic [7:0] exp_data;
    for (int f = 0; f < n_frames; f++) begin
      for (int o = 0; o < NUM_PIX; o++) begin
        exp_last = (f == n_frames - 1) && (o == NUM_PIX - 1);
        if (drop && f == 0 && o >= 10 && o <= 12) begin
          exp_data  = 8'h00;
          exp_under = 1'b1;
        end else begin
          exp_data = exp_pix[7:0];
          exp_pix++;
        end
        checkOutput("strm_sync",     32'(bus.frame_sync),  32'(o == 0));
        checkOutput("strm_data",     32'(bus.data_out),    32'(exp_data));
        checkOutput("strm_done",     32'(io_frame_done),   32'(o == NUM_PIX - 1));
        checkOutput("strm_busy",     32'(io_busy),         32'd1);
        checkOutput("strm_cfg_load", 32'(bus.config_load), 32'd0);
        checkOutput("strm_coeff",    32'(bus.coeff_out),   32'd0);
        checkOutput("strm_ready",    32'(bus.pix_ready),   32'(!exp_last));
        checkOutput("strm_underrun", 32'(io_underrun),     32'(exp_under));
        bus.pix_valid    = !(drop && f == 0 && o >= 9 && o <= 11);
        io_stop          = (f == stop_frame) && (o == 5);
        io_start         = start_mid && (f == 1) && (o == 3);
        io_coeff_wr_en   = wr_mid && (f == 0) && (o == 4);
        io_coeff_wr_addr = 5'd0;
        io_coeff_wr_data = 16'hBEEF;
        tick();
      end
    end
    bus.pix_valid  = 1'b1;
    io_stop        = 1'b0;
    io_start       = 1'b0;
    io_coeff_wr_en = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0; src_cnt = 0; exp_pix = 0; exp_under = 1'b0;
    reset_n = 1'b0; io_coeff_wr_en = 1'b0; io_coeff_wr_addr = '0; io_coeff_wr_data = '0;
    io_start = 1'b0; io_stop = 1'b0; io_num_frames = '0;
    bus.pix_valid = 1'b1; bus.pix_data = '0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    checkIdle(1'b0);

    $display("[TB] test 1: single frame with ramp mask");
    for (int i = 0; i < 25; i++) begin
      exp_coeff[i] = 16'h0100 + 16'(i);
      writeCoeff(5'(i), 16'h0100 + 16'(i));
    end
    applyStimulus(16'd1);
    checkLoad(1'b0);
    checkStream(1, 1'b0, -1, 1'b0, 1'b0);
    checkIdle(1'b0);

    $display("[TB] test 2: two back-to-back frames, writes while busy");
    applyStimulus(16'd2);
    checkLoad(1'b1);
    checkStream(2, 1'b0, -1, 1'b0, 1'b1);
    checkIdle(1'b0);

    $display("[TB] test 3/4: out-of-range write, underrun, prior mask kept");
    writeCoeff(5'd25, 16'hBEEF);
    applyStimulus(16'd1);
    checkLoad(1'b0);
    checkStream(1, 1'b1, -1, 1'b0, 1'b0);
    checkIdle(1'b1);

    $display("[TB] test 5: continuous mode stopped in frame 3");
    applyStimulus(16'd0);
    checkLoad(1'b1);
    checkStream(3, 1'b0, 2, 1'b1, 1'b0);
    checkIdle(1'b0);

    $display("[TB] test 6: reset mid-stream");
    applyStimulus(16'd1);
    checkLoad(1'b0);
    for (int i = 0; i < 7; i++) tick();
    #2;
    reset_n = 1'b0;
    #1;
    checkIdle(1'b0);
    tick();
    reset_n = 1'b1;
    src_cnt = 0; exp_pix = 0; bus.pix_data = '0;
    tick();
    checkIdle(1'b0);
    for (int i = 0; i < 25; i++) exp_coeff[i] = 16'h0000;
    applyStimulus(16'd1);
    checkLoad(1'b0);
    checkStream(1, 1'b0, -1, 1'b0, 1'b0);
    checkIdle(1'b0);
    for (int i = 0; i < 25; i++) begin
      exp_coeff[i] = 16'h0200 + 16'(3 * i);
      writeCoeff(5'(i), 16'h0200 + 16'(3 * i));
    end
    applyStimulus(16'd1);
    checkLoad(1'b0);
    checkStream(1, 1'b0, -1, 1'b0, 1'b0);
    checkIdle(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
